// File: rtl/mc68851_pkg.sv
// Shared definitions for the MC68851 coprocessor interface register bank:
// CIR byte addresses, handshake states, register ids and default primitives.
package mc68851_pkg;

  localparam logic [4:0] CIR_CONTROL    = 5'h00;
  localparam logic [4:0] CIR_RESPONSE   = 5'h02;
  localparam logic [4:0] CIR_RESTORE    = 5'h04;
  localparam logic [4:0] CIR_SAVE       = 5'h06;
  localparam logic [4:0] CIR_COMMAND    = 5'h08;
  localparam logic [4:0] CIR_CONDITION  = 5'h0C;
  localparam logic [4:0] CIR_OPERAND    = 5'h10;
  localparam logic [4:0] CIR_REG_SELECT = 5'h16;
  localparam logic [4:0] CIR_INSTR_ADDR = 5'h18;
  localparam logic [4:0] CIR_OP_ADDR    = 5'h1C;

  localparam int AB_BIT = 14;

  localparam logic [15:0] RESP_IDLE_DEF  = 16'h0802;
  localparam logic [15:0] RESP_PROTO_DEF = 16'h1C01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_BUSY = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    R_NONE,
    R_CONTROL,
    R_RESPONSE,
    R_RESTORE,
    R_SAVE,
    R_COMMAND,
    R_CONDITION,
    R_OPERAND,
    R_REG_SELECT,
    R_INSTR_ADDR,
    R_OP_ADDR
  } reg_e;

endpackage

// File: rtl/mc68851_resp_fifo.sv
// Response-primitive FIFO: synchronous push/pop/flush with occupancy count.
// A push when full is accepted only if a pop frees a slot in the same cycle.
module mc68851_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mc68851_cir.sv
// MC68851 coprocessor interface register bank between the CPU coprocessor bus
// and the MMU core. MC68851_CIR_PROTO_VIOL_EN enables protocol-violation primitives.
//
// state | meaning
// IDLE  | no command outstanding, COMMAND/CONDITION writes accepted
// PEND  | word latched, cmd_valid_o offered to core
// BUSY  | core accepted the word, waiting for done_i
module mc68851_cir
  import mc68851_pkg::*;
#(
  parameter int          DW         = 32,
  parameter int          RESP_DEPTH = 4,
  parameter logic [15:0] RESP_IDLE  = RESP_IDLE_DEF,
  parameter logic [15:0] RESP_PROTO = RESP_PROTO_DEF
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          cs_i,
  input  logic          we_i,
  input  logic [4:0]    addr_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          ack_o,
  output logic          cmd_valid_o,
  output logic          cmd_is_cond_o,
  output logic [15:0]   cmd_o,
  input  logic          cmd_ready_i,
  input  logic          done_i,
  input  logic          resp_push_i,
  input  logic [15:0]   resp_data_i,
  output logic          resp_full_o,
  output logic          opnd_valid_o,
  output logic [31:0]   opnd_o,
  input  logic          opnd_ready_i,
  input  logic          opnd_load_i,
  input  logic [31:0]   opnd_i,
  input  logic [15:0]   save_i,
  input  logic [15:0]   reg_sel_i,
  output logic          restore_we_o,
  output logic [15:0]   restore_o,
  output logic          abort_o
);
  localparam int CW = $clog2(RESP_DEPTH) + 1;

  state_e        state;
  state_e        state_nx;
  reg_e          sel;
  logic [31:0]   bus_w;
  logic [31:0]   rd32;
  logic [31:0]   instr_addr;
  logic [31:0]   op_addr;
  logic [15:0]   wd16;
  logic [15:0]   fifo_head;
  logic [15:0]   push_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_push;
  logic          fifo_pop;
  logic          push_req;
  logic          proto_viol;
  logic          wr;
  logic          rd;
  logic          abort;
  logic          cmd_wr;
  logic          opnd_cpu;
  logic          opnd_set;
  logic          lo_half;

  // 16-bit registers ride the upper lane at even word addresses on a 32-bit bus
  function automatic logic [31:0] lane16(input logic [15:0] v, input logic a1);
    lane16 = (DW == 32 && !a1) ? {v, 16'h0000} : {16'h0000, v};
  endfunction

  function automatic logic [31:0] lane32(input logic [31:0] v, input logic a1);
    if (DW == 32) lane32 = v;
    else          lane32 = a1 ? {16'h0000, v[15:0]} : {16'h0000, v[31:16]};
  endfunction

  function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] w,
                                          input logic [15:0] h, input logic a1);
    if (DW == 32) merge32 = w;
    else          merge32 = a1 ? {old[31:16], h} : {h, old[15:0]};
  endfunction

  assign bus_w   = 32'(data_i);
  assign lo_half = (DW == 16) && addr_i[1];
  assign wd16    = (DW == 32 && !addr_i[1]) ? bus_w[31:16] : bus_w[15:0];
  assign wr      = cs_i && we_i;
  assign rd      = cs_i && !we_i;

  always_comb begin
    sel = R_NONE;
    if (!addr_i[0]) begin
      case (addr_i)
        CIR_CONTROL:    sel = R_CONTROL;
        CIR_RESPONSE:   sel = R_RESPONSE;
        CIR_RESTORE:    sel = R_RESTORE;
        CIR_SAVE:       sel = R_SAVE;
        CIR_COMMAND:    sel = R_COMMAND;
        CIR_CONDITION:  sel = R_CONDITION;
        CIR_REG_SELECT: sel = R_REG_SELECT;
        default:        sel = R_NONE;
      endcase
      if (DW == 16 || !addr_i[1]) begin
        if (addr_i[4:2] == CIR_OPERAND[4:2])    sel = R_OPERAND;
        if (addr_i[4:2] == CIR_INSTR_ADDR[4:2]) sel = R_INSTR_ADDR;
        if (addr_i[4:2] == CIR_OP_ADDR[4:2])    sel = R_OP_ADDR;
      end
    end
  end

  assign abort    = wr && (sel == R_CONTROL) && wd16[AB_BIT];
  assign cmd_wr   = wr && (sel == R_COMMAND || sel == R_CONDITION);
  assign opnd_cpu = wr && (sel == R_OPERAND);
  assign opnd_set = opnd_cpu && (DW == 32 || lo_half) && !opnd_load_i;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (cmd_wr)      state_nx = ST_PEND;
      ST_PEND: if (cmd_ready_i) state_nx = ST_BUSY;
      ST_BUSY: if (done_i)      state_nx = ST_IDLE;
      default:                  state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  assign cmd_valid_o = (state == ST_PEND);

`ifdef MC68851_CIR_PROTO_VIOL_EN
  assign proto_viol = (cmd_wr && state != ST_IDLE)
                    || (rd && sel == R_OPERAND && opnd_valid_o)
                    || (cs_i && sel == R_NONE);
`else
  assign proto_viol = 1'b0;
`endif

  // Core pushes take priority over a same-cycle protocol-violation primitive
  assign push_req  = resp_push_i || proto_viol;
  assign push_data = resp_push_i ? resp_data_i : RESP_PROTO;
  assign fifo_pop  = rd && (sel == R_RESPONSE) && !fifo_empty;
  assign fifo_push = push_req && !abort;

  mc68851_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .W     (16)
  ) u_resp_fifo (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (abort),
    .din   (push_data),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign resp_full_o = (fifo_count == CW'(RESP_DEPTH));

  always_comb begin
    rd32 = '0;
    case (sel)
      R_RESPONSE:   rd32 = lane16(fifo_empty ? RESP_IDLE : fifo_head, addr_i[1]);
      R_RESTORE:    rd32 = lane16(restore_o, addr_i[1]);
      R_SAVE:       rd32 = lane16(save_i, addr_i[1]);
      R_REG_SELECT: rd32 = lane16(reg_sel_i, addr_i[1]);
      R_OPERAND:    rd32 = lane32(opnd_o, addr_i[1]);
      R_INSTR_ADDR: rd32 = lane32(instr_addr, addr_i[1]);
      R_OP_ADDR:    rd32 = lane32(op_addr, addr_i[1]);
      default:      rd32 = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      data_o        <= '0;
      ack_o         <= 1'b0;
      cmd_is_cond_o <= 1'b0;
      cmd_o         <= '0;
      opnd_valid_o  <= 1'b0;
      opnd_o        <= '0;
      restore_we_o  <= 1'b0;
      restore_o     <= '0;
      abort_o       <= 1'b0;
      instr_addr    <= '0;
      op_addr       <= '0;
    end else begin
      ack_o        <= cs_i;
      abort_o      <= abort;
      restore_we_o <= wr && (sel == R_RESTORE);
      if (rd) data_o <= rd32[DW-1:0];
      if (wr && sel == R_RESTORE) restore_o <= wd16;
      if (wr && sel == R_INSTR_ADDR) instr_addr <= merge32(instr_addr, bus_w, wd16, lo_half);
      if (wr && sel == R_OP_ADDR)    op_addr    <= merge32(op_addr, bus_w, wd16, lo_half);
      if (cmd_wr && state == ST_IDLE) begin
        cmd_o         <= wd16;
        cmd_is_cond_o <= (sel == R_CONDITION);
      end
      // abort overrides every core-side event, including an operand load
      if (!abort && opnd_load_i) opnd_o <= opnd_i;
      else if (opnd_cpu)         opnd_o <= merge32(opnd_o, bus_w, wd16, lo_half);
      if (abort)             opnd_valid_o <= 1'b0;
      else if (opnd_set)     opnd_valid_o <= 1'b1;
      else if (opnd_ready_i) opnd_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mc68851_cir.sv
// Bench for mc68851_cir: queue-based reference model checked every cycle on a
// DW=32 instance, plus directed literal checks on both a DW=32 and a DW=16 instance.
module tb_mc68851_cir;

  localparam int M_NONE = 0, M_CTRL = 1, M_RESP = 2, M_RESTORE = 3, M_SAVE = 4, M_CMD = 5,
                 M_COND = 6, M_OPND = 7, M_REGSEL = 8, M_IADDR = 9, M_OADDR = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 0, we = 0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack, cmd_valid, cmd_is_cond, resp_full, opnd_valid, restore_we, abort;
  logic [15:0] cmd_word, restore_val;
  logic [31:0] opnd_out;
  logic        cmd_ready = 0, done = 0, resp_push = 0, opnd_ready = 0, opnd_load = 0;
  logic [15:0] resp_data = '0, save = '0, reg_sel = '0;
  logic [31:0] opnd_in = '0;

  logic        b_cs = 0, b_we = 0;
  logic [4:0]  b_addr = '0;
  logic [15:0] b_wdata = '0;
  logic [15:0] b_rdata;
  logic        b_ack, b_cmd_valid, b_cmd_is_cond, b_resp_full, b_opnd_valid, b_restore_we, b_abort;
  logic [15:0] b_cmd_word, b_restore_val;
  logic [31:0] b_opnd_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc68851_cir #(.DW(32)) dut (
    .clk_i(clk), .rst_n(rst_n), .cs_i(cs), .we_i(we), .addr_i(addr), .data_i(wdata),
    .data_o(rdata), .ack_o(ack), .cmd_valid_o(cmd_valid), .cmd_is_cond_o(cmd_is_cond),
    .cmd_o(cmd_word), .cmd_ready_i(cmd_ready), .done_i(done), .resp_push_i(resp_push),
    .resp_data_i(resp_data), .resp_full_o(resp_full), .opnd_valid_o(opnd_valid),
    .opnd_o(opnd_out), .opnd_ready_i(opnd_ready), .opnd_load_i(opnd_load), .opnd_i(opnd_in),
    .save_i(save), .reg_sel_i(reg_sel), .restore_we_o(restore_we), .restore_o(restore_val),
    .abort_o(abort)
  );

  mc68851_cir #(.DW(16)) dut16 (
    .clk_i(clk), .rst_n(rst_n), .cs_i(b_cs), .we_i(b_we), .addr_i(b_addr), .data_i(b_wdata),
    .data_o(b_rdata), .ack_o(b_ack), .cmd_valid_o(b_cmd_valid), .cmd_is_cond_o(b_cmd_is_cond),
    .cmd_o(b_cmd_word), .cmd_ready_i(1'b0), .done_i(1'b0), .resp_push_i(1'b0),
    .resp_data_i(16'h0), .resp_full_o(b_resp_full), .opnd_valid_o(b_opnd_valid),
    .opnd_o(b_opnd_out), .opnd_ready_i(1'b0), .opnd_load_i(1'b0), .opnd_i(32'h0),
    .save_i(16'h0), .reg_sel_i(16'h0), .restore_we_o(b_restore_we), .restore_o(b_restore_val),
    .abort_o(b_abort)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (DW=32 instance) ----------------
  logic [15:0] q[$];
  int          m_st;            // 0 idle, 1 pending, 2 busy
  logic [15:0] m_cmd, m_restore;
  logic        m_cond, m_valid;
  logic [31:0] m_opnd, m_iaddr, m_oaddr;
  logic        e_ack, e_rwe, e_abort;
  logic [31:0] e_data;

  function automatic int dec(input logic [4:0] a);
    case (a)
      5'h00: return M_CTRL;
      5'h02: return M_RESP;
      5'h04: return M_RESTORE;
      5'h06: return M_SAVE;
      5'h08: return M_CMD;
      5'h0C: return M_COND;
      5'h10: return M_OPND;
      5'h16: return M_REGSEL;
      5'h18: return M_IADDR;
      5'h1C: return M_OADDR;
      default: return M_NONE;
    endcase
  endfunction

  function automatic logic [31:0] lane(input logic a1, input logic [15:0] v);
    return a1 ? {16'h0, v} : {v, 16'h0};
  endfunction

  task automatic model_reset();
    q.delete();
    m_st = 0; m_cmd = 0; m_restore = 0; m_cond = 0; m_valid = 0;
    m_opnd = 0; m_iaddr = 0; m_oaddr = 0;
    e_ack = 0; e_rwe = 0; e_abort = 0; e_data = 0;
  endtask

  task automatic model_step();
    int          r;
    logic [15:0] w16, pdata;
    logic        rdacc, wracc, ab, cmdwr, pop, full0, pushreq;
    r     = dec(addr);
    rdacc = cs && !we;
    wracc = cs && we;
    w16   = addr[1] ? wdata[15:0] : wdata[31:16];
    ab    = wracc && r == M_CTRL && w16[14];
    cmdwr = wracc && (r == M_CMD || r == M_COND);
    e_ack   = cs;
    e_rwe   = wracc && r == M_RESTORE;
    e_abort = ab;
    if (rdacc) begin
      case (r)
        M_RESP:    e_data = lane(addr[1], q.size() > 0 ? q[0] : 16'h0802);
        M_RESTORE: e_data = lane(addr[1], m_restore);
        M_SAVE:    e_data = lane(addr[1], save);
        M_REGSEL:  e_data = lane(addr[1], reg_sel);
        M_OPND:    e_data = m_opnd;
        M_IADDR:   e_data = m_iaddr;
        M_OADDR:   e_data = m_oaddr;
        default:   e_data = 32'h0;
      endcase
    end
    pop     = rdacc && r == M_RESP && q.size() > 0;
    full0   = (q.size() == 4);
    pushreq = resp_push;
    pdata   = resp_data;
`ifdef MC68851_CIR_PROTO_VIOL_EN
    if (!resp_push && ((cmdwr && m_st != 0) || (rdacc && r == M_OPND && m_valid) || (cs && r == M_NONE))) begin
      pushreq = 1'b1;
      pdata   = 16'h1C01;
    end
`endif
    if (ab) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (pushreq && (!full0 || pop)) q.push_back(pdata);
    end
    if (ab) m_st = 0;
    else if (m_st == 0 && cmdwr) begin
      m_st = 1; m_cmd = w16; m_cond = (r == M_COND);
    end
    else if (m_st == 1 && cmd_ready) m_st = 2;
    else if (m_st == 2 && done) m_st = 0;
    if (!ab && opnd_load) m_opnd = opnd_in;
    else if (wracc && r == M_OPND) m_opnd = wdata;
    if (ab) m_valid = 0;
    else if (wracc && r == M_OPND && !opnd_load) m_valid = 1;
    else if (opnd_ready) m_valid = 0;
    if (wracc && r == M_RESTORE) m_restore = w16;
    if (wracc && r == M_IADDR) m_iaddr = wdata;
    if (wracc && r == M_OADDR) m_oaddr = wdata;
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    chk("ack", 32'(ack), 32'(e_ack));
    chk("data", rdata, e_data);
    chk("cmd_valid", 32'(cmd_valid), 32'(m_st == 1));
    chk("cmd_is_cond", 32'(cmd_is_cond), 32'(m_cond));
    chk("cmd_word", 32'(cmd_word), 32'(m_cmd));
    chk("resp_full", 32'(resp_full), 32'(q.size() == 4));
    chk("opnd_valid", 32'(opnd_valid), 32'(m_valid));
    chk("opnd", opnd_out, m_opnd);
    chk("restore_we", 32'(restore_we), 32'(e_rwe));
    chk("restore", 32'(restore_val), 32'(m_restore));
    chk("abort", 32'(abort), 32'(e_abort));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic acc(input logic w, input logic [4:0] a, input logic [31:0] d);
    cs = 1; we = w; addr = a; wdata = d;
    step();
    cs = 0; we = 0; addr = '0; wdata = '0;
  endtask

  task automatic push(input logic [15:0] v);
    resp_push = 1; resp_data = v;
    step();
    resp_push = 0;
  endtask

  task automatic acc16(input logic w, input logic [4:0] a, input logic [15:0] d);
    b_cs = 1; b_we = w; b_addr = a; b_wdata = d;
    step();
    b_cs = 0; b_we = 0; b_addr = '0; b_wdata = '0;
  endtask

  logic [4:0] alist [14] = '{5'h00, 5'h02, 5'h04, 5'h06, 5'h08, 5'h0C, 5'h10,
                             5'h16, 5'h18, 5'h1C, 5'h0A, 5'h12, 5'h1F, 5'h02};

  initial begin
    repeat (3) step();
    rst_n = 1;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_data", rdata, 32'h0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'h0);
    chk("rst_opnd_valid", 32'(opnd_valid), 32'h0);

    acc(0, 5'h02, 0);
    chk("idle_resp_ack", 32'(ack), 32'h1);
    chk("idle_resp", rdata, 32'h0000_0802);
    step();
    chk("ack_single", 32'(ack), 32'h0);

    push(16'h1111); push(16'h2222);
    acc(0, 5'h02, 0); chk("resp_1", rdata, 32'h0000_1111);
    acc(0, 5'h02, 0); chk("resp_2", rdata, 32'h0000_2222);
    acc(0, 5'h02, 0); chk("resp_empty", rdata, 32'h0000_0802);

    acc(1, 5'h08, 32'h8000_0000);
    chk("cmd_pend", 32'(cmd_valid), 32'h1);
    chk("cmd_word", 32'(cmd_word), 32'h8000);
    cmd_ready = 1; step(); cmd_ready = 0;
    chk("cmd_taken", 32'(cmd_valid), 32'h0);
    acc(1, 5'h08, 32'h1234_0000);
    chk("cmd_ignored", 32'(cmd_word), 32'h8000);
    done = 1; step(); done = 0;

    acc(1, 5'h0C, 32'hABCD_0000);
    chk("cond_flag", 32'(cmd_is_cond), 32'h1);
    chk("cond_word", 32'(cmd_word), 32'hABCD);
    cmd_ready = 1; step(); cmd_ready = 0;
    acc(1, 5'h10, 32'hCAFE_F00D);
    chk("opnd_set", 32'(opnd_valid), 32'h1);
    push(16'hA001); push(16'hA002); push(16'hA003);
    acc(1, 5'h00, 32'h4000_0000);
    chk("abort_pulse", 32'(abort), 32'h1);
    chk("abort_opnd", 32'(opnd_valid), 32'h0);
    step();
    chk("abort_once", 32'(abort), 32'h0);
    acc(0, 5'h02, 0); chk("abort_flush", rdata, 32'h0000_0802);
    acc(1, 5'h08, 32'h5555_0000);
    chk("abort_idle", 32'(cmd_valid), 32'h1);
    cmd_ready = 1; step(); cmd_ready = 0;
`ifdef MC68851_CIR_PROTO_VIOL_EN
    acc(1, 5'h08, 32'h7777_0000);
    acc(0, 5'h02, 0); chk("proto_prim", rdata, 32'h0000_1C01);
`endif
    done = 1; step(); done = 0;

    opnd_load = 1; opnd_in = 32'h0BAD_CAFE;
    acc(1, 5'h10, 32'h1111_2222);
    opnd_load = 0;
    chk("load_wins", opnd_out, 32'h0BAD_CAFE);
    chk("load_no_valid", 32'(opnd_valid), 32'h0);

    save = 16'hA5A5; reg_sel = 16'h5A5A;
    acc(0, 5'h06, 0); chk("save", rdata, 32'h0000_A5A5);
    acc(0, 5'h16, 0); chk("reg_sel", rdata, 32'h0000_5A5A);
    acc(1, 5'h04, 32'h1357_0000);
    chk("restore_we", 32'(restore_we), 32'h1);
    chk("restore", 32'(restore_val), 32'h1357);
    acc(0, 5'h04, 0); chk("restore_rd", rdata, 32'h1357_0000);
    acc(1, 5'h18, 32'hDEAD_0018);
    acc(0, 5'h18, 0); chk("instr_addr", rdata, 32'hDEAD_0018);

    push(16'h0011); push(16'h0022); push(16'h0033); push(16'h0044);
    chk("full", 32'(resp_full), 32'h1);
    push(16'h0055);
    resp_push = 1; resp_data = 16'h0066;
    acc(0, 5'h02, 0); resp_push = 0;
    chk("full_pushpop", rdata, 32'h0000_0011);
    chk("full_kept", 32'(resp_full), 32'h1);
    acc(0, 5'h02, 0); chk("f2", rdata, 32'h0000_0022);
    acc(0, 5'h02, 0); chk("f3", rdata, 32'h0000_0033);
    acc(0, 5'h02, 0); chk("f4", rdata, 32'h0000_0044);
    acc(0, 5'h02, 0); chk("f_new", rdata, 32'h0000_0066);
    resp_push = 1; resp_data = 16'h0077;
    acc(0, 5'h02, 0); resp_push = 0;
    chk("empty_pushpop", rdata, 32'h0000_0802);
    acc(0, 5'h02, 0); chk("empty_stored", rdata, 32'h0000_0077);
    acc(0, 5'h0A, 0);
    chk("reserved_ack", 32'(ack), 32'h1);
    chk("reserved_rd", rdata, 32'h0);

    repeat (3000) begin
      cs = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      addr = alist[$urandom_range(0, 13)];
      wdata = $urandom();
      if (addr == 5'h00) wdata[30] = ($urandom_range(0, 7) == 0);
      cmd_ready = ($urandom_range(0, 2) == 0);
      done = ($urandom_range(0, 3) == 0);
      resp_push = ($urandom_range(0, 2) == 0);
      resp_data = 16'($urandom());
      opnd_ready = ($urandom_range(0, 4) == 0);
      opnd_load = ($urandom_range(0, 9) == 0);
      opnd_in = $urandom();
      save = 16'($urandom());
      reg_sel = 16'($urandom());
      step();
    end
    cs = 0; we = 0; cmd_ready = 0; done = 0; resp_push = 0; opnd_ready = 0; opnd_load = 0;

    acc16(1, 5'h10, 16'hDEAD);
    chk("dw16_hi_no_valid", 32'(b_opnd_valid), 32'h0);
    acc16(1, 5'h12, 16'hBEEF);
    chk("dw16_valid", 32'(b_opnd_valid), 32'h1);
    chk("dw16_opnd", b_opnd_out, 32'hDEAD_BEEF);
    acc16(0, 5'h10, 0); chk("dw16_rd_hi", 32'(b_rdata), 32'hDEAD);
    acc16(0, 5'h12, 0); chk("dw16_rd_lo", 32'(b_rdata), 32'hBEEF);
    acc16(0, 5'h02, 0); chk("dw16_resp", 32'(b_rdata), 32'h0802);
    acc16(1, 5'h04, 16'h2468);
    chk("dw16_restore_we", 32'(b_restore_we), 32'h1);
    chk("dw16_restore", 32'(b_restore_val), 32'h2468);
    acc16(0, 5'h04, 0); chk("dw16_restore_rd", 32'(b_rdata), 32'h2468);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc68851_cir.md
Name: mc68851_cir

Overview:
- Parametrised coprocessor interface register (CIR) bank for the MMU.
- Sits between the CPU coprocessor bus cycle decoder and the MMU execution core.
- Adds the following over a flat register file:
  - selectable bus width
  - a response-primitive FIFO
  - a command/condition handshake state machine
  - an operand hand-off channel and abort handling

Parameters:
DW, 32, CPU data bus width; legal values 16 or 32.
RESP_DEPTH, 4, response FIFO depth in entries; power of two, 2..16.
RESP_IDLE, 16'h0802, primitive returned when the response FIFO is empty.
RESP_PROTO, 16'h1C01, protocol-violation primitive (optional feature).

Ports:
clk_i  in  1  clock
rst_n  in  1  synchronous active-low reset
cs_i  in  1  single-cycle access strobe
we_i  in  1  1=write, 0=read
addr_i  in  5  CIR byte address
data_i  in  DW  write data
data_o  out  DW  registered read data
ack_o  out  1  access acknowledge
cmd_valid_o  out  1  command/condition word pending to core
cmd_is_cond_o  out  1  pending word came from CONDITION (else COMMAND)
cmd_o  out  16  command/condition word
cmd_ready_i  in  1  core accepts the word
done_i  in  1  core finished the current operation
resp_push_i  in  1  core pushes a response primitive
resp_data_i  in  16  primitive word
resp_full_o  out  1  response FIFO full
opnd_valid_o  out  1  CPU-written operand available to core
opnd_o  out  32  operand to core
opnd_ready_i  in  1  core consumes operand
opnd_load_i  in  1  core loads operand for CPU read
opnd_i  in  32  operand from core
save_i  in  16  core save-format word
reg_sel_i  in  16  core register-select word
restore_we_o  out  1  one-cycle pulse on RESTORE write
restore_o  out  16  last RESTORE value
abort_o  out  1  one-cycle pulse on CONTROL abort

Behaviour:
- Address map (byte, 16-bit units unless noted):
  - CONTROL 0x00 wo
  - RESPONSE 0x02 ro
  - RESTORE 0x04 rw
  - SAVE 0x06 ro
  - COMMAND 0x08 wo
  - CONDITION 0x0C wo
  - OPERAND 0x10 rw 32b
  - REG_SELECT 0x16 ro
  - INSTR_ADDR 0x18 rw 32b
  - OP_ADDR 0x1C rw 32b
  - all other addresses reserved
- Lane mapping:
  - DW=32: 16-bit register on [31:16] when addr_i[1]=0, on [15:0] when addr_i[1]=1; 32-bit register on the full bus at addr_i[1]=0.
  - DW=16: 16-bit registers on [15:0]; 32-bit registers are split high half at base, low half at base+2.
- Bus timing:
  - ack_o rises exactly 1 cycle after cs_i, for 1 cycle.
  - data_o is valid with ack_o and holds until the next read.
  - Reserved or wrong-direction accesses are acked with no effect; a read of such an address returns 0.
- Reset: every output is 0, FIFO is empty, state is IDLE, all registers are 0.
- State machine:
  - IDLE -> PEND on a COMMAND or CONDITION write (cmd_valid_o=1).
  - PEND -> BUSY on cmd_ready_i; cmd_valid_o drops that same edge.
  - BUSY -> IDLE on done_i.
  - A COMMAND/CONDITION write outside IDLE is ignored.
- Response FIFO:
  - A RESPONSE read pops one entry.
  - When empty, a read returns RESP_IDLE and does not pop.
  - A push when full is dropped; resp_full_o combinational from count.
  - Simultaneous push+pop when full: both proceed, count unchanged.
  - Simultaneous push+pop when empty: the read returns RESP_IDLE and the pushed entry is stored.
- Operand channel:
  - CPU OPERAND write (DW=16: on the low-half write) sets opnd_valid_o.
  - opnd_valid_o clears on opnd_ready_i.
  - opnd_load_i overwrites OPERAND; opnd_load_i wins over a same-cycle CPU write.
- SAVE and REG_SELECT reads return save_i and reg_sel_i, sampled on the cs_i cycle.
- CONTROL write with data bit 14 (AB) set:
  - state -> IDLE, FIFO flushed, cmd_valid_o and opnd_valid_o cleared, abort_o pulses.
  - Abort beats any same-cycle core event.
- RESTORE write: restore_o latched, restore_we_o pulses 1 cycle later together with ack_o.

Optional Feature:
- Macro: MC68851_CIR_PROTO_VIOL_EN.
- Defined: any of the following pushes RESP_PROTO into the FIFO (unless full):
  - a COMMAND/CONDITION write outside IDLE
  - an OPERAND read while opnd_valid_o=1
  - a reserved-address access
- Undefined: these cases are silently ignored as above.

Decomposition:
- Package mc68851_pkg holds:
  - CIR address localparams
  - state enum encoding (IDLE, PEND, BUSY)
  - AB bit index
  - default primitive constants
- One sub-module, mc68851_resp_fifo, parametrised by depth and width: push/pop/flush, count, empty/full.

Test Plan:
- Reset, then RESPONSE read -> data 16'h0802 with ack_o 1 cycle after cs_i; FIFO unchanged.
- Push 16'h1111, 16'h2222 (DW=32) -> RESPONSE reads at 0x02 return 0x1111 then 0x2222 on [15:0], then 0x0802.
- Write COMMAND 16'h8000 -> cmd_valid_o=1, cmd_o=16'h8000; cmd_ready_i -> BUSY; second COMMAND ignored; done_i -> IDLE.
- DW=16: write OPERAND 0x10=16'hDEAD, 0x12=16'hBEEF -> opnd_o=32'hDEADBEEF, opnd_valid_o set after the 0x12 write.
- In BUSY with 3 FIFO entries, write CONTROL 16'h4000 -> abort_o pulse, state IDLE, next RESPONSE read = 0x0802.
- With MC68851_CIR_PROTO_VIOL_EN, write COMMAND in BUSY -> next RESPONSE read = 16'h1C01.
